// File: rtl/load_align_unit.sv
// M-stage load path: word read addressing, S-stage store forwarding, two-beat
// handling of word-crossing loads, and sign/zero extension toward W.
module load_align_unit #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LoadM,
  input  logic [2:0]  LoadSrcM,
  input  logic [5:0]  AluResultM,
  input  logic [1:0]  AdrM,
  input  logic [31:0] MemRdData,
  output logic [5:0]  MemRdAddr,
  input  logic        MemwriteS,
  input  logic [5:0]  AluResultS,
  input  logic [1:0]  AdrS,
  input  logic [2:0]  StoreSrcS,
  input  logic [31:0] WriteDataS,
  output logic        LoadStall,
  output logic [31:0] ReadDataW,
  output logic        LoadValidW,
  output logic        LoadFaultW
);

  typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] read_data_q, read_data_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic        legal_s, split_s, fwd_hit_s;
  logic [5:0]  mem_rd_addr_s;
  logic [3:0]  mask_s;
  logic [31:0] lane_s, merged_s;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] adr);
    case (f3)
      3'b000:  return 4'b0001 << adr;
      3'b001:  return 4'b0011 << adr;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] hi, input logic [31:0] lo,
                                          input logic [1:0] adr, input logic [2:0] f3);
    logic [63:0] sh;
    sh = {hi, lo} >> {adr, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h000000, sh[7:0]};
      3'b101:  return {16'h0000, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  assign legal_s = (LoadSrcM == 3'b000) || (LoadSrcM == 3'b001) || (LoadSrcM == 3'b010) ||
                   (LoadSrcM == 3'b100) || (LoadSrcM == 3'b101);
  assign split_s = ((LoadSrcM == 3'b010) && (AdrM != 2'b00)) ||
                   (((LoadSrcM == 3'b001) || (LoadSrcM == 3'b101)) && (AdrM == 2'b11));

  // Second beat reads the following word; 6-bit add wraps 63 to 0.
  assign mem_rd_addr_s = (state_q == SPLIT) ? (AluResultM + 6'd1) : AluResultM;
  assign MemRdAddr     = mem_rd_addr_s;
  assign LoadStall     = !rst && (state_q == IDLE) && LoadM && legal_s && split_s;

  assign mask_s    = store_mask(StoreSrcS, AdrS);
  assign lane_s    = WriteDataS << {AdrS, 3'b000};
  assign fwd_hit_s = FORWARD_EN && MemwriteS && (AluResultS == mem_rd_addr_s);

  // Byte-wise merge of the pending store over the memory word.
  always_comb begin
    merged_s = MemRdData;
    for (int i = 0; i < 4; i++) begin
      if (fwd_hit_s && mask_s[i]) begin
        merged_s[8*i +: 8] = lane_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = MemRdData[8*i +: 8];
      end
    end
  end

  // Next-state and W-stage result computation.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    read_data_d = read_data_q;
    valid_d     = 1'b0;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (LoadM) begin
          if (!legal_s) begin
            fault_d     = 1'b1;
            read_data_d = 32'h0000_0000;
          end else if (split_s) begin
            lo_d    = merged_s;
            state_d = SPLIT;
          end else begin
            read_data_d = extract(merged_s, merged_s, AdrM, LoadSrcM);
            valid_d     = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SPLIT: begin
        state_d = IDLE;
        // A dropped LoadM here is a flush: abandon the load silently.
        if (LoadM) begin
          read_data_d = extract(merged_s, lo_q, AdrM, LoadSrcM);
          valid_d     = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lo_q        <= 32'h0000_0000;
      read_data_q <= 32'h0000_0000;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      read_data_q <= read_data_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
    end
  end

  assign ReadDataW  = read_data_q;
  assign LoadValidW = valid_q;
  assign LoadFaultW = fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: one forwarding and one non-forwarding
// instance share stimulus; expected W results are queued and matched on output.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        LoadM;
  logic [2:0]  LoadSrcM;
  logic [5:0]  AluResultM;
  logic [1:0]  AdrM;
  logic        MemwriteS;
  logic [5:0]  AluResultS;
  logic [1:0]  AdrS;
  logic [2:0]  StoreSrcS;
  logic [31:0] WriteDataS;

  logic [5:0]  addr_a, addr_b;
  logic [31:0] rd_a, rd_b, data_a, data_b;
  logic        stall_a, stall_b, valid_a, valid_b, fault_a, fault_b;

  logic [31:0] mem [64];
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  assign rd_a = mem[addr_a];
  assign rd_b = mem[addr_b];

  always #5 clk = ~clk;

  load_align_unit #(.FORWARD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .LoadM(LoadM), .LoadSrcM(LoadSrcM), .AluResultM(AluResultM),
    .AdrM(AdrM), .MemRdData(rd_a), .MemRdAddr(addr_a), .MemwriteS(MemwriteS),
    .AluResultS(AluResultS), .AdrS(AdrS), .StoreSrcS(StoreSrcS), .WriteDataS(WriteDataS),
    .LoadStall(stall_a), .ReadDataW(data_a), .LoadValidW(valid_a), .LoadFaultW(fault_a)
  );

  load_align_unit #(.FORWARD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .LoadM(LoadM), .LoadSrcM(LoadSrcM), .AluResultM(AluResultM),
    .AdrM(AdrM), .MemRdData(rd_b), .MemRdAddr(addr_b), .MemwriteS(MemwriteS),
    .AluResultS(AluResultS), .AdrS(AdrS), .StoreSrcS(StoreSrcS), .WriteDataS(WriteDataS),
    .LoadStall(stall_b), .ReadDataW(data_b), .LoadValidW(valid_b), .LoadFaultW(fault_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && (valid_a || fault_a)) begin
      if (exp_a_q.size() == 0) begin
        check_val("fwd_unexpected_out", {30'd0, valid_a, fault_a}, 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        check_val("fwd_data", data_a, e[31:0]);
        check_val("fwd_fault", {31'd0, fault_a}, {31'd0, e[32]});
        check_val("fwd_valid", {31'd0, valid_a}, {31'd0, !e[32]});
      end
    end
    if (!rst && (valid_b || fault_b)) begin
      if (exp_b_q.size() == 0) begin
        check_val("nofwd_unexpected_out", {30'd0, valid_b, fault_b}, 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        check_val("nofwd_data", data_b, e[31:0]);
        check_val("nofwd_fault", {31'd0, fault_b}, {31'd0, e[32]});
      end
    end
  end

  task automatic do_load(input logic [2:0] f3, input logic [5:0] wa, input logic [1:0] adr,
                         input bit split, input bit flush,
                         input logic [32:0] exp_a, input logic [32:0] exp_b);
    logic [5:0] wa_next;
    wa_next = wa + 6'd1;
    @(posedge clk); #1;
    LoadM = 1'b1; LoadSrcM = f3; AluResultM = wa; AdrM = adr;
    if (!flush) begin
      exp_a_q.push_back(exp_a);
      exp_b_q.push_back(exp_b);
    end
    @(negedge clk);
    check_val("beat1_addr", {26'd0, addr_a}, {26'd0, wa});
    check_val("beat1_stall", {31'd0, stall_a}, {31'd0, split});
    if (split) begin
      @(posedge clk); #1;
      if (flush) LoadM = 1'b0;
      @(negedge clk);
      check_val("beat2_addr", {26'd0, addr_a}, {26'd0, wa_next});
      check_val("beat2_stall", {31'd0, stall_a}, 32'd0);
    end
    @(posedge clk); #1;
    LoadM = 1'b0; MemwriteS = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    rst = 1'b1;
    LoadM = 1'b1; LoadSrcM = 3'b010; AluResultM = 6'd9; AdrM = 2'd1;
    MemwriteS = 1'b0; AluResultS = 6'd0; AdrS = 2'd0; StoreSrcS = 3'b000; WriteDataS = 32'h0;
    #12;
    check_val("rst_data", data_a, 32'h0);
    check_val("rst_valid", {31'd0, valid_a}, 32'd0);
    check_val("rst_fault", {31'd0, fault_a}, 32'd0);
    check_val("rst_stall", {31'd0, stall_a}, 32'd0);
    check_val("rst_addr", {26'd0, addr_a}, 32'd9);
    LoadM = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    mem[5]  = 32'h8899_AABB;
    mem[10] = 32'h8011_2233;
    mem[7]  = 32'h4433_2211;
    mem[8]  = 32'h8877_6655;
    mem[4]  = 32'h1122_3344;
    mem[63] = 32'hAB00_0000;
    mem[0]  = 32'h0000_00CD;

    do_load(3'b010, 6'd5, 2'd0, 1'b0, 1'b0, {1'b0, 32'h8899_AABB}, {1'b0, 32'h8899_AABB});
    do_load(3'b000, 6'd10, 2'd3, 1'b0, 1'b0, {1'b0, 32'hFFFF_FF80}, {1'b0, 32'hFFFF_FF80});
    do_load(3'b100, 6'd10, 2'd3, 1'b0, 1'b0, {1'b0, 32'h0000_0080}, {1'b0, 32'h0000_0080});
    do_load(3'b001, 6'd10, 2'd2, 1'b0, 1'b0, {1'b0, 32'hFFFF_8011}, {1'b0, 32'hFFFF_8011});
    do_load(3'b101, 6'd10, 2'd2, 1'b0, 1'b0, {1'b0, 32'h0000_8011}, {1'b0, 32'h0000_8011});
    do_load(3'b010, 6'd7, 2'd1, 1'b1, 1'b0, {1'b0, 32'h5544_3322}, {1'b0, 32'h5544_3322});

    // SB of 0xEE into byte 2 of word 4, pending in S while the load reads it.
    MemwriteS = 1'b1; AluResultS = 6'd4; AdrS = 2'd2; StoreSrcS = 3'b000; WriteDataS = 32'h0000_00EE;
    do_load(3'b010, 6'd4, 2'd0, 1'b0, 1'b0, {1'b0, 32'h11EE_3344}, {1'b0, 32'h1122_3344});
    // SH 0xBEEF at offset 1 of word 4.
    MemwriteS = 1'b1; AluResultS = 6'd4; AdrS = 2'd1; StoreSrcS = 3'b001; WriteDataS = 32'h1234_BEEF;
    do_load(3'b010, 6'd4, 2'd0, 1'b0, 1'b0, {1'b0, 32'h11BE_EF44}, {1'b0, 32'h1122_3344});

    do_load(3'b101, 6'd63, 2'd3, 1'b1, 1'b0, {1'b0, 32'h0000_CDAB}, {1'b0, 32'h0000_CDAB});

    // Flush in the second beat: no result may appear.
    do_load(3'b010, 6'd7, 2'd2, 1'b1, 1'b1, 33'd0, 33'd0);

    // Reset during the second beat.
    @(posedge clk); #1;
    LoadM = 1'b1; LoadSrcM = 3'b010; AluResultM = 6'd7; AdrM = 2'd3;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("midrst_data", data_a, 32'h0);
    check_val("midrst_valid", {31'd0, valid_a}, 32'd0);
    check_val("midrst_addr", {26'd0, addr_a}, 32'd7);
    check_val("midrst_stall", {31'd0, stall_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; LoadM = 1'b0;

    do_load(3'b010, 6'd5, 2'd0, 1'b0, 1'b0, {1'b0, 32'h8899_AABB}, {1'b0, 32'h8899_AABB});
    do_load(3'b011, 6'd5, 2'd0, 1'b0, 1'b0, {1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0000});
    do_load(3'b110, 6'd7, 2'd3, 1'b0, 1'b0, {1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0000});

    repeat (3) @(posedge clk);
    #1;
    check_val("fwd_queue_empty", exp_a_q.size(), 32'd0);
    check_val("nofwd_queue_empty", exp_b_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
